// File: rtl/avmm_burst_onchip_ram_if.sv
// Avalon-MM slave bundle for avmm_burst_onchip_ram.
//   master modport: drives the command side (chipselect, address, byteenable, read, write,
//                   writedata, burstcount) and observes waitrequest/readdata/readdatavalid.
//   slave modport:  the mirror image, used by the RAM.
interface avmm_burst_onchip_ram_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned BURST_W = 4
) ();
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic [BURST_W-1:0]    burstcount;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, address, byteenable, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, address, byteenable, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avmm_burst_onchip_ram.sv
// Single-port on-chip RAM behind an Avalon-MM slave with incrementing read/write bursts,
// byte-enabled writes and pipelined reads (readdatavalid), optionally with one extra
// output register stage.
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset (RAM contents survive it)
//   clken      clock enable; low freezes all control and the read pipeline
//   reset_req  stall request from the reset controller, behaves like clken=0
//   avs        Avalon-MM slave port (see avmm_burst_onchip_ram_if)
module avmm_burst_onchip_ram #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 5120,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned BURST_W   = 4,
  parameter int unsigned OUT_REG   = 0,
  parameter string       INIT_FILE = "onchip_ram.hex"
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic                          reset_req,
  avmm_burst_onchip_ram_if.slave        avs
);

  localparam int unsigned       BeW      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [BURST_W-1:0] rem_q, rem_d;

  logic               en;
  logic [BURST_W-1:0] bc_m1;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               rd_issue;
  logic [ADDR_W-1:0]  rd_addr;

  // reset_n folded in so nothing is accepted or stored while reset is held.
  assign en    = clken & ~reset_req & reset_n;
  // burstcount of 0 is a single beat, so the remaining-beat count is 0 as for 1.
  assign bc_m1 = (avs.burstcount == '0) ? '0 : avs.burstcount - 1'b1;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DepthW;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    wr_en    = 1'b0;
    wr_addr  = avs.address;
    rd_issue = 1'b0;
    rd_addr  = avs.address;
    unique case (state_q)
      StIdle: begin
        if (en && avs.chipselect) begin
          // Write has priority; a simultaneous read is dropped.
          if (avs.write) begin
            wr_en = 1'b1;
            if (bc_m1 != '0) begin
              state_d = StWrBurst;
              rem_d   = bc_m1;
              ptr_d   = next_ptr(avs.address);
            end
          end else if (avs.read) begin
            rd_issue = 1'b1;
            if (bc_m1 != '0) begin
              state_d = StRdBurst;
              rem_d   = bc_m1;
              ptr_d   = next_ptr(avs.address);
            end
          end
        end
      end
      StWrBurst: begin
        // Beats without write are master-side wait states.
        if (en && avs.chipselect && avs.write) begin
          wr_en   = 1'b1;
          wr_addr = ptr_q;
          ptr_d   = next_ptr(ptr_q);
          rem_d   = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = StIdle;
        end
      end
      StRdBurst: begin
        if (en) begin
          rd_issue = 1'b1;
          rd_addr  = ptr_q;
          ptr_d    = next_ptr(ptr_q);
          rem_d    = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) begin
      for (int k = 0; k < int'(BeW); k++) begin
        if (avs.byteenable[k]) mem[wr_addr][8*k +: 8] <= avs.writedata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 1 is the RAM output register, stage 2 is optional.
  // ---------------------------------------------------------------------------
  logic              rd_vld1_q;
  logic [DATA_W-1:0] rd_data1_q;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld1_q  <= 1'b0;
      rd_data1_q <= '0;
    end else if (en) begin
      rd_vld1_q <= rd_issue;
      if (rd_issue) rd_data1_q <= in_range(rd_addr) ? mem[rd_addr] : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd_vld2_q;
    logic [DATA_W-1:0] rd_data2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_vld2_q  <= 1'b0;
        rd_data2_q <= '0;
      end else if (en) begin
        rd_vld2_q <= rd_vld1_q;
        if (rd_vld1_q) rd_data2_q <= rd_data1_q;
      end
    end

    assign out_vld  = rd_vld2_q;
    assign out_data = rd_data2_q;
  end else begin : g_no_out_reg
    assign out_vld  = rd_vld1_q;
    assign out_data = rd_data1_q;
  end

  // A frozen pipeline holds its valid bit; masking with en keeps it to one pulse per word.
  assign avs.readdatavalid = out_vld & en;
  assign avs.readdata      = out_data;
  assign avs.waitrequest   = ~en | (state_q == StRdBurst);

endmodule

// File: tb/tb_avmm_burst_onchip_ram.sv
module tb_avmm_burst_onchip_ram;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 13;
  localparam int unsigned BW = 4;
  localparam int unsigned DEPTH = 5120;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  logic reset_req;

  always #5 clk = ~clk;

  avmm_burst_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus0 ();
  avmm_burst_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus1 ();

  // Both instances see identical commands; bus1 feeds the OUT_REG=1 copy.
  assign bus1.chipselect = bus0.chipselect;
  assign bus1.address    = bus0.address;
  assign bus1.byteenable = bus0.byteenable;
  assign bus1.read       = bus0.read;
  assign bus1.write      = bus0.write;
  assign bus1.writedata  = bus0.writedata;
  assign bus1.burstcount = bus0.burstcount;

  avmm_burst_onchip_ram #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BURST_W(BW), .OUT_REG(0), .INIT_FILE("")
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .avs(bus0)
  );

  avmm_burst_onchip_ram #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BURST_W(BW), .OUT_REG(1), .INIT_FILE("")
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .avs(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus0.chipselect = 1'b0;
    bus0.read       = 1'b0;
    bus0.write      = 1'b0;
    bus0.address    = '0;
    bus0.byteenable = '1;
    bus0.writedata  = '0;
    bus0.burstcount = BW'(1);
  endtask

  task automatic cmd(input logic rd, input logic wr, input int unsigned a,
                     input int unsigned bc, input logic [3:0] be, input logic [31:0] wd);
    bus0.chipselect = 1'b1;
    bus0.read       = rd;
    bus0.write      = wr;
    bus0.address    = AW'(a);
    bus0.burstcount = BW'(bc);
    bus0.byteenable = be;
    bus0.writedata  = wd;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Expected beat index visible per cycle of the stalled burst (-1 = no pulse).
  int exp0 [13] = '{-1, 0, 1, -1, -1, 2, 3, 4, 5, 6, 7, -1, -1};
  int exp1 [13] = '{-1, -1, 0, -1, -1, 1, 2, 3, 4, 5, 6, 7, -1};
  logic ck_tab [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    reset_n   = 1'b0;
    clken     = 1'b1;
    reset_req = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_wait", bus0.waitrequest, 1);
    check_eq("rst_rdv", bus0.readdatavalid, 0);
    check_eq("rst_rdata", bus0.readdata, 0);
    check_eq("rst_rdv1", bus1.readdatavalid, 0);
    next();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_wait", bus0.waitrequest, 0);
    next();

    // 1: byte-enabled write, then read-after-write
    cmd(0, 1, 5, 1, 4'hF, 32'h0);
    next();
    cmd(0, 1, 5, 1, 4'b0101, 32'h1122_3344);
    next();
    cmd(1, 0, 5, 1, 4'hF, 32'h0);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t1_rdv", bus0.readdatavalid, 1);
    check_eq("t1_data", bus0.readdata, 32'h0022_0044);
    next();
    @(negedge clk);
    check_eq("t1_rdv_off", bus0.readdatavalid, 0);
    check_eq("t1_hold", bus0.readdata, 32'h0022_0044);
    next();

    // reset_req stalls: not accepted, no read issued
    reset_req = 1'b1;
    cmd(1, 0, 5, 1, 4'hF, 32'h0);
    @(negedge clk);
    check_eq("rreq_wait", bus0.waitrequest, 1);
    next();
    idle_bus();
    reset_req = 1'b0;
    @(negedge clk);
    check_eq("rreq_rdv", bus0.readdatavalid, 0);
    next();

    // 2: wrapping write burst with a wait beat, then wrapping read burst
    cmd(0, 1, 5118, 4, 4'hF, 32'hA000_0000);
    next();
    cmd(0, 1, 0, 0, 4'hF, 32'hA000_0001);
    next();
    bus0.write = 1'b0;
    @(negedge clk);
    check_eq("t2_wb_wait", bus0.waitrequest, 0);
    next();
    cmd(0, 1, 0, 0, 4'hF, 32'hA000_0002);
    next();
    cmd(0, 1, 0, 0, 4'hF, 32'hA000_0003);
    next();
    cmd(1, 0, 5118, 4, 4'hF, 32'h0);
    @(negedge clk);
    check_eq("t2_acc_wait", bus0.waitrequest, 0);
    next();
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_wait%0d", i), bus0.waitrequest, (i < 3) ? 1 : 0);
      check_eq($sformatf("t2_rdv%0d", i), bus0.readdatavalid, 1);
      check_eq($sformatf("t2_data%0d", i), bus0.readdata, 32'hA000_0000 + i);
      next();
    end
    @(negedge clk);
    check_eq("t2_rdv_end", bus0.readdatavalid, 0);
    next();

    // 4: read+write together (write wins), burstcount 0 = single beat
    cmd(1, 1, 7, 0, 4'hF, 32'hCAFE_BABE);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t4_no_rdv", bus0.readdatavalid, 0);
    check_eq("t4_idle_wait", bus0.waitrequest, 0);
    next();
    cmd(1, 0, 7, 0, 4'hF, 32'h0);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t4_rdv", bus0.readdatavalid, 1);
    check_eq("t4_data", bus0.readdata, 32'hCAFE_BABE);
    check_eq("t4_bc0_wait", bus0.waitrequest, 0);
    next();

    // 5: out-of-range read returns 0, write is dropped
    cmd(1, 0, 6000, 1, 4'hF, 32'h0);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t5_rdv", bus0.readdatavalid, 1);
    check_eq("t5_data", bus0.readdata, 0);
    next();
    cmd(0, 1, 6000, 1, 4'hF, 32'hFFFF_FFFF);
    next();
    cmd(1, 0, 5, 1, 4'hF, 32'h0);
    next();
    cmd(1, 0, 7, 1, 4'hF, 32'h0);
    @(negedge clk);
    check_eq("t5_a5", bus0.readdata, 32'h0022_0044);
    next();
    cmd(1, 0, 6000, 1, 4'hF, 32'h0);
    @(negedge clk);
    check_eq("t5_a7", bus0.readdata, 32'hCAFE_BABE);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t5_oor_rdv", bus0.readdatavalid, 1);
    check_eq("t5_oor_data", bus0.readdata, 0);
    next();

    // 3: 8-beat read burst with clken low for 2 cycles (both latencies)
    cmd(0, 1, 16, 8, 4'hF, 32'h100);
    next();
    for (int i = 1; i < 8; i++) begin
      cmd(0, 1, 0, 0, 4'hF, 32'h100 + i);
      next();
    end
    idle_bus();
    for (int k = 0; k < 13; k++) begin
      if (k == 0) cmd(1, 0, 16, 8, 4'hF, 32'h0);
      else idle_bus();
      clken = ck_tab[k];
      @(negedge clk);
      check_eq($sformatf("t3_wait_k%0d", k), bus1.waitrequest, (k >= 1 && k <= 9) ? 1 : 0);
      check_eq($sformatf("t3_rdv0_k%0d", k), bus0.readdatavalid, (exp0[k] >= 0) ? 1 : 0);
      check_eq($sformatf("t3_rdv1_k%0d", k), bus1.readdatavalid, (exp1[k] >= 0) ? 1 : 0);
      if (exp0[k] >= 0) check_eq($sformatf("t3_d0_k%0d", k), bus0.readdata, 32'h100 + exp0[k]);
      if (exp1[k] >= 0) check_eq($sformatf("t3_d1_k%0d", k), bus1.readdata, 32'h100 + exp1[k]);
      next();
    end
    clken = 1'b1;

    // 6: reset during the 3rd beat of an 8-beat read burst
    cmd(1, 0, 16, 8, 4'hF, 32'h0);
    next();
    idle_bus();
    next();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("t6_rst_rdv0_%0d", i), bus0.readdatavalid, 0);
      check_eq($sformatf("t6_rst_rdv1_%0d", i), bus1.readdatavalid, 0);
      check_eq($sformatf("t6_rst_wait_%0d", i), bus0.waitrequest, 1);
      check_eq($sformatf("t6_rst_data_%0d", i), bus0.readdata, 0);
      next();
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("t6_post_rdv0_%0d", i), bus0.readdatavalid, 0);
      check_eq($sformatf("t6_post_rdv1_%0d", i), bus1.readdatavalid, 0);
      check_eq($sformatf("t6_post_wait_%0d", i), bus0.waitrequest, 0);
      next();
    end
    cmd(1, 0, 17, 1, 4'hF, 32'h0);
    next();
    idle_bus();
    @(negedge clk);
    check_eq("t6_rd_rdv0", bus0.readdatavalid, 1);
    check_eq("t6_rd_data0", bus0.readdata, 32'h101);
    check_eq("t6_rd_rdv1_early", bus1.readdatavalid, 0);
    next();
    @(negedge clk);
    check_eq("t6_rd_rdv1", bus1.readdatavalid, 1);
    check_eq("t6_rd_data1", bus1.readdata, 32'h101);
    next();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
